// File: rtl/sum_pkg.sv
// Shared types and defaults for the windowed accumulator.
// Holds the FSM state enum, default widths and a clamping add helper.
package sum_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int WIN_LOG2_DEF = 3;
  localparam int ACC_W_DEF    = 10;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Unsigned add clamped to 2^w-1; w must be below 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/sum_sat_add.sv
// ACC_W+1-bit accumulate with carry detect; combinational, no backpressure.
// SUM_WINDOW_ACC_SAT_EN selects clamp-to-max on carry, otherwise wrap mod 2^ACC_W.
module sum_sat_add
  import sum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] wide;

  assign wide  = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, data};
  assign carry = wide[ACC_W];

`ifdef SUM_WINDOW_ACC_SAT_EN
  logic [31:0] clamped;
  assign clamped = sat_add(32'(acc), 32'(data), ACC_W);
  assign sum     = clamped[ACC_W-1:0];
`else
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_window_acc.sv
// Sums windows of 2^WIN_LOG2 samples; result registered one cycle after the last sample, held until out_ready.
// in_ready is low while a result is held. SUM_WINDOW_ACC_SAT_EN enables saturating accumulation.
module sum_window_acc
  import sum_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_avg,
  output logic              out_ovf
);

  state_t              state, state_nxt;
  logic [ACC_W-1:0]    acc;
  logic [WIN_LOG2-1:0] cnt;
  logic                ovf;
  logic [ACC_W-1:0]    add_sum;
  logic                add_carry;
  logic [ACC_W-1:0]    add_shift;
  logic                accept;
  logic                last;

  sum_sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc   (acc),
    .data  (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  // clear vetoes acceptance so a sample alongside it is dropped
  assign accept    = in_valid && in_ready && !clear;
  assign last      = accept && (cnt == '1);
  assign add_shift = add_sum >> WIN_LOG2;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (last)      state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nxt = ST_ACCUM;
      default:                 state_nxt = ST_ACCUM;
    endcase
    if (clear) state_nxt = ST_ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ACCUM;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_avg <= '0;
      out_ovf <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_avg <= '0;
      out_ovf <= 1'b0;
    end else if (last) begin
      out_sum <= add_sum;
      out_avg <= add_shift[DATA_W-1:0];
      out_ovf <= ovf | add_carry;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      acc <= add_sum;
      cnt <= cnt + 1'b1;
      ovf <= ovf | add_carry;
    end
  end

endmodule

// File: tb/tb_sum_window_acc.sv
// Directed bench for sum_window_acc: window sums, hold, gaps, clear and async reset.
// Expected overflow result follows SUM_WINDOW_ACC_SAT_EN.
module tb_sum_window_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] out_sum;
  logic [7:0] out_avg;
  logic       out_ovf;

  int checks   = 0;
  int failures = 0;

  sum_window_acc dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and wait (bounded) for it to be taken.
  task automatic send(input logic [7:0] d);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("accept_wait", 32'(guard < 50), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [9:0] s, input logic [7:0] a,
                         input logic o);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_sum"}, 32'(out_sum), 32'(s));
    chk({tag, "_avg"}, 32'(out_avg), 32'(a));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_sum"}, 32'(out_sum), 0);
    chk({tag, "_avg"}, 32'(out_avg), 0);
    chk({tag, "_ovf"}, 32'(out_ovf), 0);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 0);
    chk("release_ready", 32'(in_ready), 1);
  endtask

  localparam logic [9:0] SUM_255 =
`ifdef SUM_WINDOW_ACC_SAT_EN
    10'd1023;
`else
    10'd1016;
`endif

  initial begin
    #12;
    chk_idle("reset");
    step();
    rst = 1'b0;
    step();

    // 8 x 10, continuous valid
    for (int i = 0; i < 7; i++) send(8'd10);
    chk("pre_last_valid", 32'(out_valid), 0);
    send(8'd10);
    chk_out("w10", 10'd80, 8'd10, 1'b0);

    // held result with in_valid asserted and no out_ready
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("hold", 10'd80, 8'd10, 1'b0);
    end
    in_valid = 1'b0;
    release_result();

    // overflow window
    for (int i = 0; i < 8; i++) send(8'd255);
    chk_out("w255", SUM_255, 8'd127, 1'b1);
    release_result();

    // samples 1..8 with gaps between them
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      step();
    end
    chk_out("gaps", 10'd36, 8'd4, 1'b0);
    release_result();

    // clear mid-window discards the partial sum and its own sample
    for (int i = 0; i < 4; i++) send(8'd50);
    in_valid = 1'b1;
    in_data  = 8'd50;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk_idle("clear_mid");
    for (int i = 0; i < 8; i++) send(8'd1);
    chk_out("after_clear", 10'd8, 8'd1, 1'b0);

    // clear during HOLD drops the result
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_idle("clear_hold");

    // async reset mid-window
    for (int i = 0; i < 3; i++) send(8'd20);
    #2 rst = 1'b1;
    #1 chk_idle("rst_mid");
    #1 rst = 1'b0;
    step();

    // async reset during HOLD
    for (int i = 0; i < 8; i++) send(8'd7);
    chk_out("w7", 10'd56, 8'd7, 1'b0);
    #2 rst = 1'b1;
    #1 chk_idle("rst_hold");
    #1 rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) send(8'd100);
    chk_out("post_rst", 10'd800, 8'd100, 1'b0);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
